// File: rtl/segment7_pkg.sv
// Shared types for the 7-segment display path: digit values, segment words,
// output polarity, and the hex-to-segment decoder.
package segment7_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [7:0] segment_output_t;
  typedef enum logic {ACTIVE_LOW, ACTIVE_HIGH} polarity_t;

  // Segment bits are g..a, bit 0 = segment a.
  function automatic logic [6:0] decode(digit_t d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/segment7_scanner_if.sv
// Display bundle between the clock/alarm datapath (master) and the scanner (slave).
interface segment7_scanner_if
  import segment7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int BRIGHT_BITS = 4
);
  logic                         enable;
  logic [DIGITS-1:0]            digit_enable;
  digit_t [DIGITS-1:0]          digit;
  logic [DIGITS-1:0]            decimal_point;
  logic [DIGITS-1:0]            blink;
  logic [BRIGHT_BITS-1:0]       brightness;
  segment_output_t              segments;
  logic [DIGITS-1:0]            segment_sel;
  logic                         frame_start;

  modport master (
    output enable, digit_enable, digit, decimal_point, blink, brightness,
    input  segments, segment_sel, frame_start
  );

  modport slave (
    input  enable, digit_enable, digit, decimal_point, blink, brightness,
    output segments, segment_sel, frame_start
  );
endinterface

// File: rtl/segment7_scanner.sv
// Self-timed multiplexed 7-segment driver: owns the digit scan, inserts a dead
// window at each slot start, and applies PWM brightness and per-digit blinking.
module segment7_scanner
  import segment7_pkg::*;
#(
  parameter int        DIGITS                = 4,
  parameter int        SCAN_DIV              = 1000,
  parameter int        DEAD_CYCLES           = 2,
  parameter int        BRIGHT_BITS           = 4,
  parameter int        BLINK_FRAMES          = 250,
  parameter polarity_t SEGMENT_SELECT_ACTIVE = ACTIVE_LOW,
  parameter polarity_t SEGMENTS_ACTIVE       = ACTIVE_LOW
) (
  input logic               clk,
  input logic               rst,
  segment7_scanner_if.slave bus
);

  localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  DEAD       = SLOT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  localparam logic [DIGITS-1:0] SEL_OFF = (SEGMENT_SELECT_ACTIVE == ACTIVE_LOW) ? '1 : '0;
  localparam segment_output_t   SEG_OFF = (SEGMENTS_ACTIVE == ACTIVE_LOW) ? '1 : '0;

  if (DIGITS < 1) begin : g_bad_digits
    $fatal(1, "segment7_scanner: DIGITS must be >= 1");
  end
  if (SCAN_DIV <= DEAD_CYCLES) begin : g_bad_scan
    $fatal(1, "segment7_scanner: SCAN_DIV must exceed DEAD_CYCLES");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $fatal(1, "segment7_scanner: BLINK_FRAMES must be >= 1");
  end

  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BRIGHT_BITS-1:0] pwm_q, pwm_d, pwm_cur;
  logic [FRAME_W-1:0]     frame_q, frame_d;
  logic                   phase_q, phase_d;
  logic [DIGITS-1:0]      sel_q, sel_d, sel_raw;
  segment_output_t        seg_q, seg_d, seg_raw;
  logic                   fs_q, fs_d;
  logic                   pwm_on, lit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    slot_d  = slot_q + 1'b1;
    idx_d   = idx_q;
    frame_d = frame_q;
    phase_d = phase_q;

    if (slot_q == SLOT_LAST) begin
      slot_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (frame_q == FRAME_LAST) begin
          frame_d = '0;
          phase_d = ~phase_q;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // The PWM phase restarts where the dead window ends, so each slot sees the same duty pattern.
    pwm_cur = (slot_q == DEAD) ? '0 : pwm_q;
    pwm_d   = pwm_cur + 1'b1;
    pwm_on  = (&bus.brightness) | (pwm_cur < bus.brightness);

    lit = bus.enable & bus.digit_enable[idx_q] & ~(bus.blink[idx_q] & phase_q)
        & (slot_q >= DEAD) & pwm_on;

    sel_raw = lit ? (DIGITS'(1) << idx_q) : '0;
    seg_raw = lit ? {bus.decimal_point[idx_q], decode(bus.digit[idx_q])} : '0;

    sel_d = (SEGMENT_SELECT_ACTIVE == ACTIVE_LOW) ? ~sel_raw : sel_raw;
    seg_d = (SEGMENTS_ACTIVE == ACTIVE_LOW) ? ~seg_raw : seg_raw;
    fs_d  = (idx_q == '0) && (slot_q == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is sampled only on the clock edge like any other input.
    if (rst) begin
      slot_q  <= '0;
      idx_q   <= '0;
      pwm_q   <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_OFF;
      fs_q    <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      frame_q <= frame_d;
      phase_q <= phase_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.segment_sel = sel_q;
  assign bus.segments    = seg_q;
  assign bus.frame_start = fs_q;

endmodule
